unidade_controle_rodadas_param: RTL

//  Parametrised Moore control unit for the memory game with progressive rounds.

---
 rtl/unidade_controle_rodadas_param_if.sv | 39 +++
 rtl/unidade_controle_rodadas_param.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas_param_if.sv
// Control/status bundle between the memory-game control unit and its surroundings.
//   master : drives the game inputs (iniciar, jogada, igual, enderecoIgualRodada, fimL,
//            modo_timeout) and observes the datapath controls and game status.
//   slave  : the control unit; consumes the inputs and drives zeraE/contaE, zeraL/contaL,
//            zeraR/registraR, pronto, acertou, errou, timeout and db_estado.
interface unidade_controle_rodadas_param_if #(
    parameter int unsigned ESTADO_W = 4
);
    logic                iniciar;
    logic                jogada;
    logic                igual;
    logic                enderecoIgualRodada;
    logic                fimL;
    logic                modo_timeout;

    logic                zeraE;
    logic                contaE;
    logic                zeraL;
    logic                contaL;
    logic                zeraR;
    logic                registraR;
    logic                pronto;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic [ESTADO_W-1:0] db_estado;

    modport master (
        output iniciar, jogada, igual, enderecoIgualRodada, fimL, modo_timeout,
        input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
        input  pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        input  iniciar, jogada, igual, enderecoIgualRodada, fimL, modo_timeout,
        output zeraE, contaE, zeraL, contaL, zeraR, registraR,
        output pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_rodadas_param.sv
// Moore control unit for the progressive-rounds memory game. Round k needs k correct plays;
// the game is won after the last round (fimL), lost on a wrong play, or lost on a per-play
// timeout when that mode was selected at game start.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   ctrl  : slave side of the game bundle (inputs from detector/datapath, datapath controls,
//           status flags and db_estado state code)
module unidade_controle_rodadas_param #(
    parameter int unsigned TIMEOUT_CICLOS = 5000,
    parameter int unsigned ESTADO_W       = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    unidade_controle_rodadas_param_if.slave    ctrl
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CICLOS);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        Inicial             = 4'd0,
        InicializaElementos = 4'd1,
        InicioRodada        = 4'd2,
        EsperaJogada        = 4'd3,
        RegistraJogada      = 4'd4,
        ComparaJogada       = 4'd5,
        ProximaJogada       = 4'd6,
        ProximaRodada       = 4'd7,
        FinalAcertou        = 4'd10,
        FinalTimeout        = 4'd13,
        FinalErrou          = 4'd14
    } estado_e;

    estado_e          estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             modo_q, modo_d;
    logic [3:0]       codigo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= Inicial;
            cnt_q    <= '0;
            modo_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            modo_q   <= modo_d;
        end
    end

    always_comb begin
        estado_d        = estado_q;
        cnt_d           = '0;       // counter only survives while waiting for a play
        modo_d          = modo_q;
        codigo          = estado_q;
        ctrl.zeraE      = 1'b0;
        ctrl.contaE     = 1'b0;
        ctrl.zeraL      = 1'b0;
        ctrl.contaL     = 1'b0;
        ctrl.zeraR      = 1'b0;
        ctrl.registraR  = 1'b0;
        ctrl.pronto     = 1'b0;
        ctrl.acertou    = 1'b0;
        ctrl.errou      = 1'b0;
        ctrl.timeout    = 1'b0;

        case (estado_q)
            Inicial: begin
                ctrl.zeraE = 1'b1;
                ctrl.zeraL = 1'b1;
                ctrl.zeraR = 1'b1;
                if (ctrl.iniciar) estado_d = InicializaElementos;
            end
            InicializaElementos: begin
                ctrl.zeraE = 1'b1;
                ctrl.zeraL = 1'b1;
                ctrl.zeraR = 1'b1;
                modo_d     = ctrl.modo_timeout;
                estado_d   = InicioRodada;
            end
            InicioRodada: begin
                ctrl.zeraE = 1'b1;
                estado_d   = EsperaJogada;
            end
            EsperaJogada: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
                // A play arriving on the expiry cycle still counts.
                if (ctrl.jogada) begin
                    estado_d = RegistraJogada;
                end else if (modo_q && (cnt_q == CntMax)) begin
                    estado_d = FinalTimeout;
                end
            end
            RegistraJogada: begin
                ctrl.registraR = 1'b1;
                estado_d       = ComparaJogada;
            end
            ComparaJogada: begin
                if (!ctrl.igual) begin
                    estado_d = FinalErrou;
                end else if (!ctrl.enderecoIgualRodada) begin
                    estado_d = ProximaJogada;
                end else if (ctrl.fimL) begin
                    estado_d = FinalAcertou;
                end else begin
                    estado_d = ProximaRodada;
                end
            end
            ProximaJogada: begin
                ctrl.contaE = 1'b1;
                estado_d    = EsperaJogada;
            end
            ProximaRodada: begin
                ctrl.contaL = 1'b1;
                estado_d    = InicioRodada;
            end
            FinalAcertou: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
                if (ctrl.iniciar) estado_d = InicializaElementos;
            end
            FinalErrou: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
                if (ctrl.iniciar) estado_d = InicializaElementos;
            end
            FinalTimeout: begin
                ctrl.pronto  = 1'b1;
                ctrl.errou   = 1'b1;
                ctrl.timeout = 1'b1;
                if (ctrl.iniciar) estado_d = InicializaElementos;
            end
            default: begin
                estado_d = Inicial;
                codigo   = 4'hF;
            end
        endcase
    end

    assign ctrl.db_estado = ESTADO_W'(codigo);

endmodule
